// File: rtl/skolem_pkg.sv
// Shared types and bit-vector helpers for the Skolem sweep harness.
package skolem_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t DRIVE  = 3'd1;
  localparam state_t SAMPLE = 3'd2;
  localparam state_t SEARCH = 3'd3;
  localparam state_t NEXT   = 3'd4;
  localparam state_t DONE   = 3'd5;

  localparam int SK_W = 4;
  localparam int NVEC = 2**(2*SK_W);

  // Signed compare of the low w bits: shift the sign bit up to bit 31.
  function automatic logic bvsgt(input logic [31:0] a, input logic [31:0] b, input int w);
    logic signed [31:0] as_;
    logic signed [31:0] bs_;
    as_ = $signed(a << (32 - w));
    bs_ = $signed(b << (32 - w));
    return as_ > bs_;
  endfunction

  function automatic logic [31:0] bvmul_trunc(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] p;
    p = a * b;
    return p & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/skolem_cond_eval.sv
// Combinational invertibility check: (s*c mod 2^W) >s t.
module skolem_cond_eval
  import skolem_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic [W-1:0] c,
  output logic         ok
);
  logic [31:0] prod;

  always_comb begin
    prod = bvmul_trunc(32'(s), 32'(c), W);
    ok   = bvsgt(prod, 32'(t), W);
  end
endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep of all (s,t) pairs through the Skolem netlist, classifying
// each answer as pass, genuine fail or vacuous.
module skolem_sweep_checker
  import skolem_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   sk_s,
  output logic [W-1:0]   sk_t,
  input  logic [W-1:0]   sk_x,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   pass_cnt,
  output logic [2*W:0]   fail_cnt,
  output logic [2*W:0]   vac_cnt,
  output logic           ff_valid,
  output logic [W-1:0]   ff_s,
  output logic [W-1:0]   ff_t,
  output logic [W-1:0]   ff_x
);
  localparam logic [3:0]   SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [2*W:0] ONE_C     = (2*W+1)'(1);

  state_t             state;
  logic [2*W-1:0]     idx;
  logic [3:0]         settle_cnt;
  logic [W-1:0]       cand;
  logic [W-1:0]       xq;
  logic [W-1:0]       c_mux;
  logic               ok;

  // idx only moves on entry to DRIVE, so the operands are stable through SAMPLE/SEARCH.
  assign sk_s = idx[W-1:0];
  assign sk_t = idx[2*W-1:W];
  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  assign c_mux = (state == SAMPLE) ? sk_x : cand;

  skolem_cond_eval #(.W(W)) u_eval (
    .s  (sk_s),
    .t  (sk_t),
    .c  (c_mux),
    .ok (ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      cand       <= '0;
      xq         <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      vac_cnt    <= '0;
      ff_valid   <= 1'b0;
      ff_s       <= '0;
      ff_t       <= '0;
      ff_x       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pass_cnt   <= '0;
          fail_cnt   <= '0;
          vac_cnt    <= '0;
          ff_valid   <= 1'b0;
          ff_s       <= '0;
          ff_t       <= '0;
          ff_x       <= '0;
          idx        <= '0;
          settle_cnt <= '0;
          state      <= DRIVE;
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_M1) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 4'd1;
        end
        SAMPLE: begin
          xq   <= sk_x;
          cand <= '0;
          if (ok) begin
            pass_cnt <= pass_cnt + ONE_C;
            state    <= NEXT;
          end else begin
            state <= SEARCH;
          end
        end
        SEARCH: begin
          // A witness exists, so the netlist answer was a genuine miss.
          if (ok) begin
            fail_cnt <= fail_cnt + ONE_C;
            if (!ff_valid) begin
              ff_valid <= 1'b1;
              ff_s     <= sk_s;
              ff_t     <= sk_t;
              ff_x     <= xq;
            end
            state <= NEXT;
          end else if (cand == {W{1'b1}}) begin
            vac_cnt <= vac_cnt + ONE_C;
            state   <= NEXT;
          end else begin
            cand <= cand + 1'b1;
          end
        end
        NEXT: begin
          settle_cnt <= '0;
          if (idx == {2*W{1'b1}}) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Self-checking bench: per-cycle trace and totals predicted from the
// invertibility rule, with several netlist stubs.
module tb_skolem_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   sel = 0;
  int   md  = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] rnd_tab [256];

  logic [3:0] s1, t1, x1, fs1, ft1, fx1;
  logic       busy1, done1, ffv1;
  logic [8:0] p1, f1, v1;
  logic [3:0] s3, t3, x3, fs3, ft3, fx3;
  logic       busy3, done3, ffv3;
  logic [8:0] p3, f3, v3;
  logic       start1, start3;

  assign start1 = (sel == 0) ? start : 1'b0;
  assign start3 = (sel == 1) ? start : 1'b0;

  always #5 clk = ~clk;

  function automatic int sv(int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic bit cond(int s, int c, int t);
    return sv((s * c) % 16) > sv(t);
  endfunction

  function automatic logic [3:0] ideal(int s, int t);
    for (int c = 0; c < 16; c++) if (cond(s, c, t)) return 4'(c);
    return 4'd0;
  endfunction

  function automatic logic [3:0] stub_x(int mode, int s, int t);
    case (mode)
      0:       return ideal(s, t);
      1:       return 4'd0;
      default: return rnd_tab[t*16 + s];
    endcase
  endfunction

  always_comb begin
    case (md)
      0:       x1 = ideal(int'(s1), int'(t1));
      1:       x1 = 4'd0;
      default: x1 = rnd_tab[{t1, s1}];
    endcase
  end

  // Netlist that answers one cycle late.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) x3 <= 4'd0;
    else x3 <= ideal(int'(s3), int'(t3));

  skolem_sweep_checker #(.W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sk_s(s1), .sk_t(t1), .sk_x(x1),
    .busy(busy1), .done(done1), .pass_cnt(p1), .fail_cnt(f1), .vac_cnt(v1),
    .ff_valid(ffv1), .ff_s(fs1), .ff_t(ft1), .ff_x(fx1)
  );

  skolem_sweep_checker #(.W(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sk_s(s3), .sk_t(t3), .sk_x(x3),
    .busy(busy3), .done(done3), .pass_cnt(p3), .fail_cnt(f3), .vac_cnt(v3),
    .ff_valid(ffv3), .ff_s(fs3), .ff_t(ft3), .ff_x(fx3)
  );

  logic [3:0] m_s, m_t, m_fs, m_ft, m_fx;
  logic       m_busy, m_done, m_ffv;
  logic [8:0] m_p, m_f, m_v;

  always_comb begin
    if (sel == 1) begin
      m_s = s3; m_t = t3; m_busy = busy3; m_done = done3; m_p = p3; m_f = f3; m_v = v3;
      m_ffv = ffv3; m_fs = fs3; m_ft = ft3; m_fx = fx3;
    end else begin
      m_s = s1; m_t = t1; m_busy = busy1; m_done = done1; m_p = p1; m_f = f1; m_v = v1;
      m_ffv = ffv1; m_fs = fs1; m_ft = ft1; m_fx = fx1;
    end
  end

  typedef struct {
    int s, t, busy, done, cnt_chk;
    int p, f, v, ffv, fs, ft, fx;
  } exp_t;

  exp_t exp_q[$];
  int e_pass, e_fail, e_vac, e_ffv, e_fs, e_ft, e_fx, vac_t7;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Predict the whole sweep: one entry per clock cycle after start is accepted.
  task automatic build(int settle, int mode);
    exp_t e;
    e_pass = 0; e_fail = 0; e_vac = 0; e_ffv = 0; e_fs = 0; e_ft = 0; e_fx = 0; vac_t7 = 0;
    for (int v = 0; v < 256; v++) begin
      int s, t, x, hit, lat;
      s = v % 16; t = v / 16;
      x = int'(stub_x(mode, s, t));
      hit = -1;
      for (int c = 0; c < 16 && hit < 0; c++) if (cond(s, c, t)) hit = c;
      if (cond(s, x, t)) begin
        e_pass++; lat = settle + 2;
      end else if (hit >= 0) begin
        e_fail++; lat = settle + 2 + hit + 1;
        if (e_ffv == 0) begin e_ffv = 1; e_fs = s; e_ft = t; e_fx = x; end
      end else begin
        e_vac++; lat = settle + 2 + 16;
        if (t == 7) vac_t7++;
      end
      for (int k = 0; k < lat; k++) begin
        e = '{s, t, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(e);
      end
    end
    e = '{15, 15, 0, 1, 1, e_pass, e_fail, e_vac, e_ffv, e_fs, e_ft, e_fx};
    exp_q.push_back(e);
    e.done = 0;
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("busy", int'(m_busy), e.busy);
      chk("done", int'(m_done), e.done);
      chk("sk_s", int'(m_s), e.s);
      chk("sk_t", int'(m_t), e.t);
      if (e.cnt_chk != 0) begin
        chk("pass_cnt", int'(m_p), e.p);
        chk("fail_cnt", int'(m_f), e.f);
        chk("vac_cnt", int'(m_v), e.v);
        chk("ff_valid", int'(m_ffv), e.ffv);
        chk("ff_s", int'(m_fs), e.fs);
        chk("ff_t", int'(m_ft), e.ft);
        chk("ff_x", int'(m_fx), e.fx);
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(m_busy), 0);
    chk({tag, "_done"}, int'(m_done), 0);
    chk({tag, "_sk"}, int'({m_t, m_s}), 0);
    chk({tag, "_cnts"}, int'(m_p) + int'(m_f) + int'(m_v), 0);
    chk({tag, "_ff"}, int'({m_ffv, m_fs, m_ft, m_fx}), 0);
  endtask

  task automatic kick(int settle, int mode);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    build(settle, mode);
  endtask

  task automatic run(int settle, int mode, bit stress);
    kick(settle, mode);
    for (int n = 0; n < 8000 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      start = stress && (exp_q.size() == 3 || exp_q.size() == 500);
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      chk("sweep_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    chk("cond_3_2_5", int'(cond(3, 2, 5)), 1);

    sel = 0; md = 0;
    run(1, 0, 1'b0);
    chk("ideal_fail", e_fail, 0);
    chk("ideal_sum", e_pass + e_vac, 256);
    chk("ideal_t7_vac", vac_t7, 16);

    md = 1;
    run(1, 1, 1'b0);
    chk("x0_pass", e_pass, 128);
    chk("x0_ffv", e_ffv, 1);
    chk("x0_ff_st", e_fs * 16 + e_ft, 16);
    chk("x0_ff_x", e_fx, 0);

    for (int i = 0; i < 256; i++)
      rnd_tab[i] = ($urandom_range(0, 1) != 0) ? ideal(i % 16, i / 16) : 4'($urandom_range(0, 15));
    md = 2;
    run(1, 2, 1'b1);
    chk("rand_sum", e_pass + e_fail + e_vac, 256);

    sel = 1;
    run(3, 0, 1'b0);

    // Abort a sweep at idx 100, then restart cleanly.
    sel = 0; md = 0;
    kick(1, 0);
    begin
      int n;
      n = 0;
      while (!(m_t == 4'd6 && m_s == 4'd4) && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("reach_idx100", n < 2000 ? 1 : 0, 1);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1 chk_zero("midreset_hold");
    rst_n = 1'b1;
    run(1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
